// File: rtl/port_arbiter_if.sv
// ============================================================================
//  Module   : port_arbiter_if
//  Brief    : Flit handshake bundle between the transceivers, the output-port
//             arbiter and the downstream link.
//  Revision : 1.0
// ============================================================================
`default_nettype none

interface port_arbiter_if #(
  parameter int DATA_SIZE = 32,
  parameter int ADDR_SIZE = 4,
  parameter int REQ_NUM   = 5
);
  localparam int BUS_SIZE = DATA_SIZE + ADDR_SIZE + 1;

  logic [REQ_NUM-1:0]          req_i;
  logic [BUS_SIZE*REQ_NUM-1:0] data_i;
  logic [REQ_NUM-1:0]          ack_o;
  logic                        r_ready_in;
  logic                        wr_ready_out;
  logic [BUS_SIZE-1:0]         data_o;

  // master = arbiter side, slave = transceivers plus downstream link
  modport master (
    input  req_i, data_i, r_ready_in,
    output ack_o, wr_ready_out, data_o
  );

  modport slave (
    output req_i, data_i, r_ready_in,
    input  ack_o, wr_ready_out, data_o
  );
endinterface

`default_nettype wire

// File: rtl/port_arbiter.sv
// ============================================================================
//  Module   : port_arbiter
//  Brief    : Round-robin output-port scheduler with packet-level locking and
//             forced release after MAX_FLITS flits without a tail.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module port_arbiter #(
  parameter int DATA_SIZE = 32,
  parameter int ADDR_SIZE = 4,
  parameter int REQ_NUM   = 5,
  parameter int MAX_FLITS = 16
) (
  input  wire logic         clk,
  input  wire logic         a_rst_n,
  port_arbiter_if.master    link,
  output logic [REQ_NUM-1:0] grant_o,
  output logic              busy_o,
  output logic              len_err_o
);

  localparam int BUS_SIZE = DATA_SIZE + ADDR_SIZE + 1;
  localparam int IDX_W    = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;
  localparam int CNT_W    = $clog2(MAX_FLITS + 1);

  localparam logic [CNT_W-1:0]   MAX_CNT   = CNT_W'(MAX_FLITS);
  localparam logic [REQ_NUM-1:0] GRANT_ONE = REQ_NUM'(1);
  localparam logic [IDX_W-1:0]   LAST_RST  = IDX_W'(REQ_NUM - 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_SEND     = 2'd1,
    S_WAIT_ACK = 2'd2,
    S_RELEASE  = 2'd3
  } state_t;

  state_t              state_q;
  logic [IDX_W-1:0]    last_q;
  logic [IDX_W-1:0]    gidx_q;
  logic [CNT_W-1:0]    flit_cnt_q;
  logic                tail_q;
  logic [REQ_NUM-1:0]  ack_q;
  logic [REQ_NUM-1:0]  grant_q;
  logic                wr_q;
  logic [BUS_SIZE-1:0] data_q;
  logic                busy_q;
  logic                len_err_q;
  logic [IDX_W-1:0]    win_d;

  function automatic logic [IDX_W-1:0] rr_idx(input logic [IDX_W-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= REQ_NUM) s = s - REQ_NUM;
    return IDX_W'(s);
  endfunction

  // Scan from farthest to nearest so the requester closest after last wins.
  always_comb begin
    win_d = last_q;
    for (int k = REQ_NUM; k >= 1; k--) begin
      if (link.req_i[rr_idx(last_q, k)]) win_d = rr_idx(last_q, k);
    end
  end

  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      state_q    <= S_IDLE;
      last_q     <= LAST_RST;
      gidx_q     <= '0;
      flit_cnt_q <= '0;
      tail_q     <= 1'b0;
      ack_q      <= '0;
      grant_q    <= '0;
      wr_q       <= 1'b0;
      data_q     <= '0;
      busy_q     <= 1'b0;
      len_err_q  <= 1'b0;
    end else begin
      len_err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (|link.req_i) begin
            gidx_q  <= win_d;
            grant_q <= GRANT_ONE << win_d;
            busy_q  <= 1'b1;
            state_q <= S_SEND;
          end
        end
        S_SEND: begin
          if (link.req_i[gidx_q]) begin
            if (!link.r_ready_in) begin
              data_q  <= link.data_i[gidx_q*BUS_SIZE +: BUS_SIZE];
              wr_q    <= 1'b1;
              state_q <= S_WAIT_ACK;
            end
          end else if (flit_cnt_q == '0) begin
            // Owner withdrew before sending anything: drop the grant, keep last.
            grant_q <= '0;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        S_WAIT_ACK: begin
          if (link.r_ready_in) begin
            wr_q       <= 1'b0;
            ack_q      <= grant_q;
            flit_cnt_q <= flit_cnt_q + CNT_W'(1);
            tail_q     <= data_q[ADDR_SIZE];
            state_q    <= S_RELEASE;
          end
        end
        S_RELEASE: begin
          if (!link.req_i[gidx_q] && !link.r_ready_in) begin
            ack_q <= '0;
            if (tail_q || (flit_cnt_q == MAX_CNT)) begin
              last_q     <= gidx_q;
              flit_cnt_q <= '0;
              grant_q    <= '0;
              busy_q     <= 1'b0;
              len_err_q  <= !tail_q;
              state_q    <= S_IDLE;
            end else begin
              state_q <= S_SEND;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign link.ack_o        = ack_q;
  assign link.wr_ready_out = wr_q;
  assign link.data_o       = data_q;
  assign grant_o           = grant_q;
  assign busy_o            = busy_q;
  assign len_err_o         = len_err_q;

endmodule

`default_nettype wire

// File: tb/tb_port_arbiter.sv
// ============================================================================
//  Module   : tb_port_arbiter
//  Brief    : Randomised scoreboard bench for port_arbiter with packet-level
//             round-robin reference model.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_port_arbiter;

  localparam int DATA_SIZE = 32;
  localparam int ADDR_SIZE = 4;
  localparam int REQ_NUM   = 5;
  localparam int MAX_FLITS = 4;
  localparam int BUS_SIZE  = DATA_SIZE + ADDR_SIZE + 1;
  localparam int TMO       = 2000;

  logic clk = 1'b0;
  logic a_rst_n = 1'b0;
  logic [REQ_NUM-1:0] grant_o;
  logic busy_o;
  logic len_err_o;

  port_arbiter_if #(.DATA_SIZE(DATA_SIZE), .ADDR_SIZE(ADDR_SIZE), .REQ_NUM(REQ_NUM)) intf();

  port_arbiter #(
    .DATA_SIZE(DATA_SIZE), .ADDR_SIZE(ADDR_SIZE), .REQ_NUM(REQ_NUM), .MAX_FLITS(MAX_FLITS)
  ) dut (
    .clk(clk), .a_rst_n(a_rst_n), .link(intf),
    .grant_o(grant_o), .busy_o(busy_o), .len_err_o(len_err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int                  id;
    logic [BUS_SIZE-1:0] flit;
  } exp_t;

  exp_t scb[$];
  int checks = 0;
  int errors = 0;
  logic [BUS_SIZE-1:0] strm [REQ_NUM][16];
  int slen [REQ_NUM];
  int exp_lenerr = 0;
  int seen_lenerr = 0;
  logic done = 1'b0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  task automatic check_outputs_zero(input string tag);
    check({tag, "_ack"}, 64'(intf.ack_o), 0);
    check({tag, "_wr"}, 64'(intf.wr_ready_out), 0);
    check({tag, "_data"}, 64'(intf.data_o), 0);
    check({tag, "_grant"}, 64'(grant_o), 0);
    check({tag, "_busy"}, 64'(busy_o), 0);
    check({tag, "_lenerr"}, 64'(len_err_o), 0);
  endtask

  // Monitor: invariants every cycle, scoreboard pop on each new flit presented.
  initial begin
    logic prev_wr;
    logic prev_le;
    exp_t e;
    prev_wr = 1'b0;
    prev_le = 1'b0;
    forever begin
      @(negedge clk);
      if (a_rst_n) begin
        check("grant_onehot0", 64'($onehot0(grant_o)), 1);
        check("busy_vs_grant", 64'(busy_o), 64'(grant_o != '0));
        check("ack_outside_grant", 64'(intf.ack_o & ~grant_o), 0);
        if (len_err_o) begin
          seen_lenerr++;
          check("len_err_single_cycle", 64'(prev_le), 0);
        end
        if (intf.wr_ready_out && !prev_wr) begin
          if (scb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_flit: got %0h from grant %0b expected none", intf.data_o, grant_o);
          end else begin
            e = scb.pop_front();
            check("flit_data", 64'(intf.data_o), 64'(e.flit));
            check("flit_grant", 64'(grant_o), 64'(1) << e.id);
          end
        end
      end
      prev_wr = intf.wr_ready_out;
      prev_le = len_err_o;
    end
  end

  task automatic do_reset();
    a_rst_n = 1'b0;
    intf.req_i = '0;
    intf.r_ready_in = 1'b0;
    repeat (2) @(negedge clk);
    check_outputs_zero("reset");
    a_rst_n = 1'b1;
  endtask

  task automatic wait_ack(input int r, input logic lvl, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < TMO; n++) begin
      @(negedge clk);
      if (intf.ack_o[r] == lvl) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL ack_timeout: requester %0d ack stuck at %0b expected %0b", r, intf.ack_o[r], lvl);
    end
  endtask

  // Gaps only inside a segment; at a segment boundary the next flit is raised
  // immediately so every pending requester takes part in the next arbitration.
  task automatic drive_req(input int r);
    int cnt;
    bit ok;
    cnt = 0;
    for (int i = 0; i < slen[r]; i++) begin
      intf.data_i[r*BUS_SIZE +: BUS_SIZE] = strm[r][i];
      intf.req_i[r] = 1'b1;
      wait_ack(r, 1'b1, ok);
      if (!ok) return;
      intf.req_i[r] = 1'b0;
      wait_ack(r, 1'b0, ok);
      if (!ok) return;
      cnt++;
      if (strm[r][i][ADDR_SIZE] || cnt == MAX_FLITS) cnt = 0;
      else repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  task automatic drive_down();
    while (!done) begin
      @(negedge clk);
      if (intf.wr_ready_out && !intf.r_ready_in) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        intf.r_ready_in = 1'b1;
      end else if (!intf.wr_ready_out && intf.r_ready_in) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        intf.r_ready_in = 1'b0;
      end
    end
    intf.r_ready_in = 1'b0;
  endtask

  task automatic random_round(input int round);
    int pos [REQ_NUM];
    int last;
    int cnt;
    int g;
    int c;
    exp_t e;
    logic [BUS_SIZE-1:0] f;

    do_reset();
    for (int r = 0; r < REQ_NUM; r++) begin
      slen[r] = $urandom_range(0, 9);
      for (int i = 0; i < slen[r]; i++) begin
        strm[r][i] = {$urandom(), ($urandom_range(0, 2) == 0), 4'($urandom())};
        if (i == slen[r] - 1) strm[r][i][ADDR_SIZE] = 1'b1;
      end
      pos[r] = 0;
    end
    if (round == 0) begin
      slen[0] = 5;
      for (int i = 0; i < 5; i++) strm[0][i] = {$urandom(), (i == 4), 4'(i)};
    end

    // Reference: packets granted whole, round-robin after the last owner.
    exp_lenerr = 0;
    seen_lenerr = 0;
    last = REQ_NUM - 1;
    forever begin
      g = -1;
      for (int k = 1; k <= REQ_NUM; k++) begin
        c = (last + k) % REQ_NUM;
        if (g < 0 && pos[c] < slen[c]) g = c;
      end
      if (g < 0) break;
      cnt = 0;
      do begin
        f = strm[g][pos[g]];
        pos[g]++;
        cnt++;
        e.id = g;
        e.flit = f;
        scb.push_back(e);
      end while (!f[ADDR_SIZE] && cnt < MAX_FLITS);
      if (!f[ADDR_SIZE]) exp_lenerr++;
      last = g;
    end

    done = 1'b0;
    fork
      begin
        fork
          drive_req(0);
          drive_req(1);
          drive_req(2);
          drive_req(3);
          drive_req(4);
        join
        done = 1'b1;
      end
      drive_down();
    join
    repeat (3) @(negedge clk);
    check("round_scb_empty", 64'(scb.size()), 0);
    check("len_err_count", 64'(seen_lenerr), 64'(exp_lenerr));
    check("idle_after_round", 64'(busy_o), 0);
  endtask

  initial begin
    exp_t e;
    intf.req_i = '0;
    intf.data_i = '0;
    intf.r_ready_in = 1'b0;

    do_reset();

    // Latency and asynchronous reset in WAIT_ACK.
    e.id = 0;
    e.flit = {32'hA5A5_0001, 1'b0, 4'h3};
    scb.push_back(e);
    intf.data_i[0 +: BUS_SIZE] = e.flit;
    intf.req_i[0] = 1'b1;
    @(negedge clk);
    check("latency_after_1_edge", 64'(intf.wr_ready_out), 0);
    @(negedge clk);
    check("latency_after_2_edges", 64'(intf.wr_ready_out), 1);
    #2 a_rst_n = 1'b0;
    #1 check_outputs_zero("async_reset");
    intf.req_i = '0;
    @(negedge clk);
    a_rst_n = 1'b1;
    intf.data_i[3*BUS_SIZE +: BUS_SIZE] = '1;
    intf.req_i[0] = 1'b1;
    intf.req_i[3] = 1'b1;
    @(negedge clk);
    check("priority_after_reset", 64'(grant_o), 64'b00001);

    // Withdraw before any flit.
    do_reset();
    intf.req_i[2] = 1'b1;
    intf.req_i[3] = 1'b1;
    @(negedge clk);
    check("withdraw_grant2", 64'(grant_o), 64'b00100);
    check("withdraw_busy", 64'(busy_o), 1);
    intf.req_i[2] = 1'b0;
    @(negedge clk);
    check("withdraw_idle_grant", 64'(grant_o), 0);
    check("withdraw_no_wr", 64'(intf.wr_ready_out), 0);
    @(negedge clk);
    check("withdraw_next_grant3", 64'(grant_o), 64'b01000);
    check("withdraw_still_no_wr", 64'(intf.wr_ready_out), 0);

    for (int round = 0; round < 6; round++) random_round(round);

    check("final_scb_empty", 64'(scb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/port_arbiter.md
Name: port_arbiter

Overview:
- Output-port scheduler for the switch. Shares one output link among REQ_NUM requesting transceivers: 4 neighbour ports plus the local port.
- Grants the link round-robin with packet-level locking. Once a requester wins, all its flits pass through until the tail flit is accepted. Packets from different requesters are never interleaved.
- Sits between the per-input transceivers and the output link. It uses the same wr_ready/r_ready four-phase flit handshake on both sides.

Parameters:
- DATA_SIZE, 32: payload bits per flit.
- ADDR_SIZE, 4: destination address bits per flit.
- REQ_NUM, 5: number of requesters (PORTS_NUM+1).
- MAX_FLITS, 16: maximum flits per packet before a forced release.
- BUS_SIZE (localparam): DATA_SIZE+ADDR_SIZE+1.
- Flit layout: [ADDR_SIZE-1:0] = dest address; bit [ADDR_SIZE] = tail flag; upper bits = payload.

Ports:
- clk  in  1  clock, rising edge.
- a_rst_n  in  1  asynchronous, active-low reset.
- req_i  in  REQ_NUM  per-requester wr_ready (flit valid, held until acked).
- data_i  in  BUS_SIZE*REQ_NUM  per-requester flit; slice i = data_i[i*BUS_SIZE+:BUS_SIZE].
- ack_o  out  REQ_NUM  per-requester r_ready (flit taken).
- r_ready_in  in  1  downstream accept.
- wr_ready_out  out  1  downstream flit valid.
- data_o  out  BUS_SIZE  forwarded flit.
- grant_o  out  REQ_NUM  one-hot current owner; 0 when idle.
- busy_o  out  1  a grant is held.
- len_err_o  out  1  one-cycle pulse on forced release.

Behaviour:
- Reset (a_rst_n=0, takes effect immediately, including mid-packet):
  - Outputs: ack_o=0, wr_ready_out=0, data_o=0, grant_o=0, busy_o=0, len_err_o=0.
  - Internal: state=IDLE, last=REQ_NUM-1, flit_cnt=0.
  - A packet interrupted by reset is abandoned.
- All outputs are registered.
- IDLE:
  - If req_i != 0: choose the first set bit searching (last+1) mod REQ_NUM upward, wrapping.
  - Set grant_o (one-hot), set busy_o=1, go to SEND. Takes 1 cycle.
- SEND:
  - If req_i[g]=1 and r_ready_in=0: data_o <= slice g, wr_ready_out <= 1, go to WAIT_ACK.
  - If req_i[g]=0 and flit_cnt=0 (withdrawn before any flit): clear the grant, go to IDLE, leave last unchanged.
  - If req_i[g]=0 and flit_cnt>0: stay in SEND (hold the lock).
- WAIT_ACK: when r_ready_in=1, do all of the following, then go to RELEASE:
  - wr_ready_out <= 0
  - ack_o[g] <= 1
  - flit_cnt <= flit_cnt+1
  - tail latched from data_o[ADDR_SIZE]
- RELEASE: wait until req_i[g]=0 and r_ready_in=0 (both four-phase returns complete), then ack_o[g] <= 0 and:
  - Tail latched: last <= g, flit_cnt <= 0, grant_o <= 0, busy_o <= 0, go to IDLE.
  - No tail and flit_cnt == MAX_FLITS: as for tail, plus len_err_o pulses high for 1 cycle.
  - Otherwise: go to SEND.
- Minimum flit period: 3 cycles (SEND→WAIT_ACK→RELEASE, each with instant responses).
- Minimum latency from req_i to wr_ready_out: 2 edges.
- data_o holds its last value after release; it is meaningful only while wr_ready_out=1.
- Requests arriving mid-packet from other requesters are only considered at the next IDLE.
- Simultaneous requests: exactly one winner per the round-robin order.
- A single requester re-requesting after its own packet wins again, after 1 IDLE cycle.
- flit_cnt width: clog2(MAX_FLITS+1) bits; never wraps (forced release at MAX_FLITS).
- grant_o is always one-hot or zero; ack_o is only ever set on the granted bit.
- Any unreachable state encoding returns to IDLE.

Test Plan:
- Single packet:
  - Stimulus: requester 0 sends 3 flits (tail on the 3rd); downstream acks 1 cycle after wr_ready_out.
  - Required: data_o shows the 3 flits in order; grant_o=5'b00001 throughout; busy_o drops after the 3rd RELEASE; last=0.
- Round-robin:
  - Stimulus: requesters 1 and 3 each hold 1-flit packets continuously from reset.
  - Required: grant order 1,3,1,3; never two bits set in grant_o.
- Packet locking:
  - Stimulus: requester 4 raises req mid-way through a 4-flit packet from requester 2.
  - Required: all 4 flits from 2 are forwarded first; then grant_o=5'b10000.
- Length error:
  - Stimulus: MAX_FLITS=4; requester 0 sends 5 flits with no tail.
  - Required: len_err_o pulses once after the 4th flit; grant released; requester 0 re-arbitrates for the 5th flit.
- Withdraw:
  - Stimulus: requester 2 wins, then drops req in SEND before any flit.
  - Required: return to IDLE; wr_ready_out never rises; a pending requester 3 is granted next.
- Reset mid-packet:
  - Stimulus: assert a_rst_n=0 during WAIT_ACK.
  - Required: all outputs 0 immediately, without waiting for a clock edge; after release, requester 0 has priority.
